cache_refill_ctrl: RTL
======================

# cache_refill_ctrl

Parametrised, clocked successor to the combinational cache control decode. It owns the cache miss state register and the word counter internally. Line length is a parameter, and RAM transfers advance on a per-word acknowledge instead of a fixed-latency assumption. It sits between the I/D `cache_2way` instances and the RAM port, and drives a CPU stall.

## Interface
- `WORDS_PER_LINE`, 8: words per cache line; power of two, ≥2.
- `WSEL_W`, `$clog2(WORDS_PER_LINE)`: width of word select and counter.
- `clk` input 1: sole clock.
- `rst_n` input 1: reset, asynchronous and active-low.
- `ic_read_in`, `dc_read_in`, `dc_write_in` input 1 each: CPU requests.
- `ic_hit_in`, `ic_valid_in`, `dc_hit_in`, `dc_valid_in`, `dc_dirty_in` input 1 each: `cache_2way` responses.
- `ic_word_sel_in`, `dc_word_sel_in` input `WSEL_W`: CPU word offsets.
- `dc_byte_w_en_in` input 4: CPU byte enables.
- `ram_ack_in` input 1: RAM completed the current word (read data valid, or write accepted).
- `ic_enable`, `ic_cmp`, `ic_write`, `ic_valid` output 1 each; `ic_word_sel` output `WSEL_W`; `ic_byte_w_en` output 4.
- `dc_enable`, `dc_cmp`, `dc_write`, `dc_valid` output 1 each; `dc_word_sel` output `WSEL_W`; `dc_byte_w_en` output 4.
- `ram_en`, `ram_write` output 1; `ram_addr_sel` output 2 (00 ic, 01 dc, 11 dc writeback).
- `ic_fill_from_dc` output 1: I-cache fill word is taken from the D-cache, not RAM.
- `stall` output 1: high whenever state ≠ NORMAL.
- `state_out` output 3; `counter_out` output `WSEL_W`: debug and verification visibility.

## Operation
- Registered state ∈ {NORMAL, IC_MISS, DC_MISS, DC_WB, DBL_MISS, DBL_WB} and registered counter `cnt`. All other outputs are combinational decode of state, `cnt` and inputs.
- **NORMAL:**
  - `ic_enable=ic_read_in`, `ic_cmp=1`, `ic_write=0`, `ic_byte_w_en=0`.
  - `dc_enable=dc_read_in|dc_write_in`, `dc_cmp=1`, `dc_write=dc_write_in`, `dc_byte_w_en=dc_byte_w_en_in`.
  - Word selects pass through from the CPU. `ram_en=0`, `cnt←0`.
  - Define `icm = ic_enable & ~(ic_hit_in & ic_valid_in)` and `dcm = dc_enable & ~(dc_hit_in & dc_valid_in)`.
  - Next state:
    - dcm & icm → DBL_WB if dirty, else DBL_MISS.
    - dcm only → DC_WB if dirty, else DC_MISS.
    - icm only → IC_MISS.
    - Otherwise stay in NORMAL.
- **IC_MISS / DBL_MISS (I-fill):**
  - `ic_enable=1`, `ic_cmp=0`, `ic_write=1`, `ic_byte_w_en=1111`.
  - `dc_enable=1`, `dc_cmp=1` (coherence probe), `dc_write=0`.
  - Both word selects = `cnt`. `ram_addr_sel=00`, `ram_write=0`.
  - If `dc_hit_in&dc_valid_in`: `ic_fill_from_dc=1`, `ram_en=0`, and the word completes this cycle. Otherwise `ram_en=1`, and the word completes on `ram_ack_in`.
- **DC_MISS (D-fill):**
  - `dc_enable=1`, `dc_cmp=0`, `dc_write=1`, `dc_byte_w_en=1111`, `dc_word_sel=cnt`.
  - I-cache idle. `ram_addr_sel=01`, `ram_en=1`, `ram_write=0`.
  - A word completes on ack.
- **DC_WB / DBL_WB (writeback):**
  - `dc_enable=1`, `dc_cmp=0`, `dc_write=0`, `dc_word_sel=cnt`.
  - `ram_addr_sel=11`, `ram_en=1`, `ram_write=1`.
  - A word completes on ack.
- **Word completion:**
  - If `cnt==WORDS_PER_LINE-1`: `cnt←0` and the state advances:
    - IC_MISS → NORMAL
    - DC_MISS → NORMAL
    - DC_WB → DC_MISS
    - DBL_WB → DBL_MISS
    - DBL_MISS → DC_MISS
  - Otherwise `cnt←cnt+1` and the state holds.
  - With no completion, everything holds and the outputs repeat.
- In every state, `ic_valid=dc_valid=1`.

## Timing
- Async reset: state=NORMAL, `cnt=0` immediately. Outputs then show the NORMAL decode: `stall=0`, `ram_en=0`, `ic_fill_from_dc=0`, `state_out=0`, `counter_out=0`.
- Reset mid-fill aborts the fill with no further RAM cycles. Array invalidation is the caches' responsibility.
- The miss decision is made in the same cycle as the lookup; the fill state is entered on the next edge.
- Minimum miss penalties:
  - Clean D-miss: `WORDS_PER_LINE` cycles.
  - Dirty D-miss: `2×WORDS_PER_LINE` cycles.
  - Dirty double miss: `3×WORDS_PER_LINE` cycles.
  - Each RAM wait cycle adds one cycle.
- `ram_ack_in` is ignored in NORMAL, and ignored in I-fill while a D-cache hit supplies the word. An ack arriving with completion already true advances only once.
- `cnt` never exceeds `WORDS_PER_LINE-1` and never wraps silently.

## Structure
- Shared package/header `status.vh`:
  - State encodings (NORMAL=0, IC_MISS, DC_MISS, DC_WB, DBL_MISS, DBL_WB).
  - `ram_addr_sel` codes.
- One sub-module, `cache_word_counter`:
  - Parameters: `WSEL_W`, `LAST`.
  - Ports: `clk`, `rst_n`, `clr`, `inc`, `cnt`, `last`.
- The remainder is a single next-state/decode `always @(*)` plus the state flop.

## Test plan
- Reset with `WORDS_PER_LINE=8`, idle inputs → `state_out=0`, `stall=0`, `ram_en=0`. Assert `rst_n` low mid-DC_MISS at `cnt=3` → `state_out=0`, `cnt=0` in the same cycle.
- Clean D-read miss, ack every cycle → 8 cycles of DC_MISS with `dc_word_sel` 0..7, `dc_byte_w_en=1111`, then NORMAL, `stall=0`.
- Dirty D-miss with ack every other cycle → 16 cycles of DC_WB (`ram_write=1`, `ram_addr_sel=11`), then 16 cycles of DC_MISS; counter holds on non-ack cycles.
- Dirty double miss → DBL_WB(8) → DBL_MISS(8) → DC_MISS(8) → NORMAL; `ram_addr_sel` sequence 11, 00, 01.
- IC_MISS with `dc_hit_in&dc_valid_in=1` on words 2–4 → `ic_fill_from_dc=1` and `ram_en=0` on those words, which complete without ack. Repeat with `WORDS_PER_LINE=4`: NORMAL is reached after the 4th word.

Source files
------------

// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache refill controller: state encodings,
// RAM address-select codes and the end-of-line state transition.
package cache_refill_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_NORMAL   = 3'd0,
    ST_IC_MISS  = 3'd1,
    ST_DC_MISS  = 3'd2,
    ST_DC_WB    = 3'd3,
    ST_DBL_MISS = 3'd4,
    ST_DBL_WB   = 3'd5
  } state_e;

  localparam logic [1:0] RAM_SEL_IC = 2'b00;
  localparam logic [1:0] RAM_SEL_DC = 2'b01;
  localparam logic [1:0] RAM_SEL_WB = 2'b11;

  // State reached once the last word of a line has completed.
  // A double miss fills the I-cache first, then the D-cache.
  function automatic state_e line_done_next(input state_e s);
    case (s)
      ST_DC_WB:    return ST_DC_MISS;
      ST_DBL_WB:   return ST_DBL_MISS;
      ST_DBL_MISS: return ST_DC_MISS;
      default:     return ST_NORMAL;
    endcase
  endfunction

endpackage

// File: rtl/cache_refill_ctrl_word_counter.sv
// Word counter for line transfers. Saturates at LAST so it can never wrap;
// the controller clears it explicitly when a line finishes.
module cache_word_counter #(
  parameter int                WSEL_W = 3,
  parameter logic [WSEL_W-1:0] LAST   = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [WSEL_W-1:0] cnt,
  output logic              last
);

  logic [WSEL_W-1:0] cnt_q;

  // Counter register: clear has priority, increment stops at LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + WSEL_W'(1);
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == LAST);

endmodule

// File: rtl/cache_refill_ctrl.sv
// Clocked cache refill controller between the I/D caches and the RAM port.
//
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   NORMAL      | caches serve CPU lookups, miss detection, no RAM traffic
//   IC_MISS     | I-cache line fill (word from D-cache on a probe hit)
//   DC_MISS     | D-cache line fill from RAM
//   DC_WB       | dirty D-cache line written back, then DC_MISS
//   DBL_WB      | writeback for a double miss, then DBL_MISS
//   DBL_MISS    | I-fill for a double miss, then DC_MISS
module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int WSEL_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ic_read_in,
  input  logic              dc_read_in,
  input  logic              dc_write_in,
  input  logic              ic_hit_in,
  input  logic              ic_valid_in,
  input  logic              dc_hit_in,
  input  logic              dc_valid_in,
  input  logic              dc_dirty_in,
  input  logic [WSEL_W-1:0] ic_word_sel_in,
  input  logic [WSEL_W-1:0] dc_word_sel_in,
  input  logic [3:0]        dc_byte_w_en_in,
  input  logic              ram_ack_in,
  output logic              ic_enable,
  output logic              ic_cmp,
  output logic              ic_write,
  output logic              ic_valid,
  output logic [WSEL_W-1:0] ic_word_sel,
  output logic [3:0]        ic_byte_w_en,
  output logic              dc_enable,
  output logic              dc_cmp,
  output logic              dc_write,
  output logic              dc_valid,
  output logic [WSEL_W-1:0] dc_word_sel,
  output logic [3:0]        dc_byte_w_en,
  output logic              ram_en,
  output logic              ram_write,
  output logic [1:0]        ram_addr_sel,
  output logic              ic_fill_from_dc,
  output logic              stall,
  output logic [2:0]        state_out,
  output logic [WSEL_W-1:0] counter_out
);

  localparam logic [WSEL_W-1:0] LAST = WSEL_W'(WORDS_PER_LINE - 1);

  state_e            state_q, state_d;
  logic [WSEL_W-1:0] cnt;
  logic              cnt_last;
  logic              cnt_clr;
  logic              cnt_inc;
  logic              word_done;
  logic              dc_probe_hit;
  logic              icm;
  logic              dcm;

  assign dc_probe_hit = dc_hit_in & dc_valid_in;
  assign icm = ic_read_in & ~(ic_hit_in & ic_valid_in);
  assign dcm = (dc_read_in | dc_write_in) & ~dc_probe_hit;

  // Word completion: I-fill completes on a D-cache probe hit or on ack,
  // every other transfer state waits for the RAM ack.
  always_comb begin
    word_done = 1'b0;
    case (state_q)
      ST_IC_MISS, ST_DBL_MISS:       word_done = dc_probe_hit | ram_ack_in;
      ST_DC_MISS, ST_DC_WB, ST_DBL_WB: word_done = ram_ack_in;
      default:                       word_done = 1'b0;
    endcase
  end

  assign cnt_clr = (state_q == ST_NORMAL) | (word_done & cnt_last);
  assign cnt_inc = word_done & ~cnt_last;

  cache_word_counter #(
    .WSEL_W (WSEL_W),
    .LAST   (LAST)
  ) u_word_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (cnt_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: miss classification in NORMAL, line-end advance elsewhere.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL: begin
        if (dcm && icm) begin
          state_d = dc_dirty_in ? ST_DBL_WB : ST_DBL_MISS;
        end else if (dcm) begin
          state_d = dc_dirty_in ? ST_DC_WB : ST_DC_MISS;
        end else if (icm) begin
          state_d = ST_IC_MISS;
        end
      end
      ST_IC_MISS, ST_DC_MISS, ST_DC_WB, ST_DBL_MISS, ST_DBL_WB: begin
        if (word_done && cnt_last) begin
          state_d = line_done_next(state_q);
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  // Output decode of state, counter and inputs.
  always_comb begin
    ic_enable       = 1'b0;
    ic_cmp          = 1'b0;
    ic_write        = 1'b0;
    ic_byte_w_en    = 4'b0000;
    ic_word_sel     = ic_word_sel_in;
    dc_enable       = 1'b0;
    dc_cmp          = 1'b0;
    dc_write        = 1'b0;
    dc_byte_w_en    = 4'b0000;
    dc_word_sel     = dc_word_sel_in;
    ram_en          = 1'b0;
    ram_write       = 1'b0;
    ram_addr_sel    = RAM_SEL_IC;
    ic_fill_from_dc = 1'b0;
    case (state_q)
      ST_NORMAL: begin
        ic_enable    = ic_read_in;
        ic_cmp       = 1'b1;
        dc_enable    = dc_read_in | dc_write_in;
        dc_cmp       = 1'b1;
        dc_write     = dc_write_in;
        dc_byte_w_en = dc_byte_w_en_in;
      end
      ST_IC_MISS, ST_DBL_MISS: begin
        ic_enable       = 1'b1;
        ic_write        = 1'b1;
        ic_byte_w_en    = 4'b1111;
        ic_word_sel     = cnt;
        // D-cache is probed so the fill can use a newer copy held there
        dc_enable       = 1'b1;
        dc_cmp          = 1'b1;
        dc_word_sel     = cnt;
        ram_addr_sel    = RAM_SEL_IC;
        ic_fill_from_dc = dc_probe_hit;
        ram_en          = ~dc_probe_hit;
      end
      ST_DC_MISS: begin
        dc_enable    = 1'b1;
        dc_write     = 1'b1;
        dc_byte_w_en = 4'b1111;
        dc_word_sel  = cnt;
        ram_addr_sel = RAM_SEL_DC;
        ram_en       = 1'b1;
      end
      ST_DC_WB, ST_DBL_WB: begin
        dc_enable    = 1'b1;
        dc_word_sel  = cnt;
        ram_addr_sel = RAM_SEL_WB;
        ram_en       = 1'b1;
        ram_write    = 1'b1;
      end
      default: ;
    endcase
  end

  assign ic_valid    = 1'b1;
  assign dc_valid    = 1'b1;
  assign stall       = (state_q != ST_NORMAL);
  assign state_out   = state_q;
  assign counter_out = cnt;

endmodule
